sgpr_ckpt: RTL and testbench

SGPR_CKPT -- requirements
Module: sgpr_ckpt

---
 rtl/sgpr_ckpt.sv | 136 +++++++++++++
 tb/tb_sgpr_ckpt.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sgpr_ckpt.sv
// Scalar register file with a shadow checkpoint bank and a sequential rollback engine.
// Dirty words are restored one index per cycle; per-word even parity flags stored-data faults.
module sgpr_ckpt #(
   parameter int unsigned RV32E      = 0,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned PARITY_EN  = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  test_en_i,
   input  logic [4:0]            raddr_a_i,
   input  logic [4:0]            raddr_b_i,
   output logic [DATA_WIDTH-1:0] rdata_a_o,
   output logic [DATA_WIDTH-1:0] rdata_b_o,
   output logic                  perr_a_o,
   output logic                  perr_b_o,
   input  logic [4:0]            waddr_a_i,
   input  logic [DATA_WIDTH-1:0] wdata_a_i,
   input  logic                  we_a_i,
   input  logic                  err_inj_i,
   input  logic                  ckpt_i,
   input  logic                  replay_i,
   output logic                  busy_o,
   output logic                  replay_done_o
);

   localparam int unsigned ADDR_WIDTH = (RV32E != 0) ? 4 : 5;
   localparam int unsigned NUM_WORDS  = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] IdxFirst = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH-1:0] IdxLast  = '1;

   typedef enum logic [1:0] {StIdle, StRestore, StDone} state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] idx_q, idx_d;
   logic [DATA_WIDTH-1:0] work_q [NUM_WORDS];
   logic [DATA_WIDTH-1:0] work_d [NUM_WORDS];
   logic [DATA_WIDTH-1:0] shad_q [NUM_WORDS];
   logic [DATA_WIDTH-1:0] shad_d [NUM_WORDS];
   logic [NUM_WORDS-1:0]  wpar_q, wpar_d, spar_q, spar_d, dirty_q, dirty_d;

   logic                  wr_en, wr_par;
   logic [ADDR_WIDTH-1:0] wr_idx, ra_idx, rb_idx;
   logic                  ra_ok, rb_ok;
   logic                  unused_test_en;

   assign unused_test_en = test_en_i;

   assign wr_idx = waddr_a_i[ADDR_WIDTH-1:0];
   assign wr_en  = we_a_i && !replay_i && (waddr_a_i != 5'd0) && (32'(waddr_a_i) < NUM_WORDS);
   assign wr_par = (PARITY_EN != 0) && ((^wdata_a_i) ^ err_inj_i);

   // Word 0 is never written, so its storage stays zero and needs no read masking.
   assign ra_idx = raddr_a_i[ADDR_WIDTH-1:0];
   assign rb_idx = raddr_b_i[ADDR_WIDTH-1:0];
   assign ra_ok  = 32'(raddr_a_i) < NUM_WORDS;
   assign rb_ok  = 32'(raddr_b_i) < NUM_WORDS;

   assign rdata_a_o = ra_ok ? work_q[ra_idx] : '0;
   assign rdata_b_o = rb_ok ? work_q[rb_idx] : '0;
   assign perr_a_o  = ra_ok && (PARITY_EN != 0) && ((^work_q[ra_idx]) != wpar_q[ra_idx]);
   assign perr_b_o  = rb_ok && (PARITY_EN != 0) && ((^work_q[rb_idx]) != wpar_q[rb_idx]);

   assign busy_o        = (state_q != StIdle);
   assign replay_done_o = (state_q == StDone);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      work_d  = work_q;
      shad_d  = shad_q;
      wpar_d  = wpar_q;
      spar_d  = spar_q;
      dirty_d = dirty_q;
      unique case (state_q)
         StIdle: begin
            if (replay_i) begin
               state_d = StRestore;
               idx_d   = IdxFirst;
            end else begin
               if (wr_en) begin
                  work_d[wr_idx]  = wdata_a_i;
                  wpar_d[wr_idx]  = wr_par;
                  dirty_d[wr_idx] = 1'b1;
               end
               // Snapshot includes the write landing on the same edge.
               if (ckpt_i) begin
                  shad_d  = work_d;
                  spar_d  = wpar_d;
                  dirty_d = '0;
               end
            end
         end
         StRestore: begin
            if (dirty_q[idx_q]) begin
               work_d[idx_q]  = shad_q[idx_q];
               wpar_d[idx_q]  = spar_q[idx_q];
               dirty_d[idx_q] = 1'b0;
            end
            if (idx_q == IdxLast) begin
               state_d = StDone;
               idx_d   = IdxFirst;
            end else begin
               idx_d = idx_q + IdxFirst;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         idx_q   <= IdxFirst;
         work_q  <= '{default: '0};
         shad_q  <= '{default: '0};
         wpar_q  <= '0;
         spar_q  <= '0;
         dirty_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         work_q  <= work_d;
         shad_q  <= shad_d;
         wpar_q  <= wpar_d;
         spar_q  <= spar_d;
         dirty_q <= dirty_d;
      end
   end

endmodule

// File: tb/tb_sgpr_ckpt.sv
// Bench for sgpr_ckpt: two configurations driven in lockstep, checked against a
// rollback-level reference model plus directed vectors and corner-case sequences.
module tb_sgpr_ckpt;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic        test_en, we, inj, ckpt, replay;
   logic [4:0]  ra, rb, waddr;
   logic [31:0] wdata;

   logic [31:0] rda0, rdb0, rda1, rdb1;
   logic        pea0, peb0, pea1, peb1, busy0, busy1, done0, done1;

   int ntests = 0;
   int nfail  = 0;

   sgpr_ckpt #(.RV32E(0), .DATA_WIDTH(32), .PARITY_EN(1)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .test_en_i(test_en),
      .raddr_a_i(ra), .raddr_b_i(rb), .rdata_a_o(rda0), .rdata_b_o(rdb0),
      .perr_a_o(pea0), .perr_b_o(peb0), .waddr_a_i(waddr), .wdata_a_i(wdata),
      .we_a_i(we), .err_inj_i(inj), .ckpt_i(ckpt), .replay_i(replay),
      .busy_o(busy0), .replay_done_o(done0)
   );

   sgpr_ckpt #(.RV32E(1), .DATA_WIDTH(32), .PARITY_EN(0)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .test_en_i(test_en),
      .raddr_a_i(ra), .raddr_b_i(rb), .rdata_a_o(rda1), .rdata_b_o(rdb1),
      .perr_a_o(pea1), .perr_b_o(peb1), .waddr_a_i(waddr), .wdata_a_i(wdata),
      .we_a_i(we), .err_inj_i(inj), .ckpt_i(ckpt), .replay_i(replay),
      .busy_o(busy1), .replay_done_o(done1)
   );

   // Model: a rollback makes the whole working bank equal the checkpoint; mbusy counts
   // remaining busy cycles (last one is the done cycle).
   int unsigned nw [2] = '{32, 16};
   bit          pe [2] = '{1'b1, 1'b0};
   logic [31:0] mw [2][32];
   logic [31:0] ms [2][32];
   logic        mp [2][32];
   logic        msp[2][32];
   int          mbusy[2];

   task automatic mreset();
      for (int k = 0; k < 2; k++) begin
         mbusy[k] = 0;
         for (int i = 0; i < 32; i++) begin
            mw[k][i] = '0; ms[k][i] = '0; mp[k][i] = 1'b0; msp[k][i] = 1'b0;
         end
      end
   endtask

   task automatic mstep();
      for (int k = 0; k < 2; k++) begin
         if (mbusy[k] > 0) begin
            mbusy[k]--;
         end else if (replay) begin
            mbusy[k] = int'(nw[k]);
            for (int i = 0; i < 32; i++) begin
               mw[k][i] = ms[k][i]; mp[k][i] = msp[k][i];
            end
         end else begin
            if (we && waddr != 5'd0 && 32'(waddr) < nw[k]) begin
               mw[k][waddr] = wdata;
               mp[k][waddr] = pe[k] ? ((^wdata) ^ inj) : 1'b0;
            end
            if (ckpt) begin
               for (int i = 0; i < 32; i++) begin
                  ms[k][i] = mw[k][i]; msp[k][i] = mp[k][i];
               end
            end
         end
      end
   endtask

   function automatic logic [31:0] erd(int k, logic [4:0] a);
      return (32'(a) < nw[k]) ? mw[k][a] : 32'h0;
   endfunction

   function automatic logic eperr(int k, logic [4:0] a);
      return (32'(a) < nw[k]) && pe[k] && ((^mw[k][a]) != mp[k][a]);
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic chk_dut(int k, logic [31:0] a, logic [31:0] b, logic pa, logic pb,
                          logic bz, logic dn);
      chk($sformatf("d%0d_busy", k), 32'(bz), 32'(mbusy[k] > 0));
      chk($sformatf("d%0d_done", k), 32'(dn), 32'(mbusy[k] == 1));
      if (mbusy[k] == 0) begin
         chk($sformatf("d%0d_rdata_a[%0d]", k, ra), a, erd(k, ra));
         chk($sformatf("d%0d_rdata_b[%0d]", k, rb), b, erd(k, rb));
         chk($sformatf("d%0d_perr_a[%0d]", k, ra), 32'(pa), 32'(eperr(k, ra)));
         chk($sformatf("d%0d_perr_b[%0d]", k, rb), 32'(pb), 32'(eperr(k, rb)));
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      mstep();
      #1;
      chk_dut(0, rda0, rdb0, pea0, peb0, busy0, done0);
      chk_dut(1, rda1, rdb1, pea1, peb1, busy1, done1);
   endtask

   task automatic idle();
      we = 1'b0; inj = 1'b0; ckpt = 1'b0; replay = 1'b0;
   endtask

   task automatic wr(logic [4:0] a, logic [31:0] d, logic e);
      idle();
      we = 1'b1; waddr = a; wdata = d; inj = e;
      cycle();
      idle();
   endtask

   task automatic rd_chk(string nm, logic [4:0] a, logic [31:0] e, logic ep);
      idle();
      ra = a;
      cycle();
      chk({nm, "_data"}, rda0, e);
      chk({nm, "_perr"}, 32'(pea0), 32'(ep));
   endtask

   // Busy and done cycle counts per DUT; random writes/checkpoints hit the busy window.
   task automatic run_replay();
      int rc0 = 0, rc1 = 0, dn0 = 0, dn1 = 0;
      idle();
      replay = 1'b1;
      for (int i = 0; i < 33; i++) begin
         cycle();
         if (busy0 && !done0) rc0++;
         if (busy1 && !done1) rc1++;
         if (done0) dn0++;
         if (done1) dn1++;
         replay = 1'b0;
         we     = 1'($urandom_range(0, 1));
         waddr  = 5'($urandom);
         wdata  = $urandom;
         inj    = 1'($urandom_range(0, 1));
         ckpt   = 1'($urandom_range(0, 1));
      end
      idle();
      chk("restore_len_d0", rc0, 31);
      chk("restore_len_d1", rc1, 15);
      chk("done_pulses_d0", dn0, 1);
      chk("done_pulses_d1", dn1, 1);
   endtask

   typedef struct {
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic        inj;
      logic        ckpt;
      logic [4:0]  ra;
      logic [31:0] exp_rd;
      logic        exp_perr;
   } vec_t;

   vec_t vecs[8];

   initial begin
      vecs[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0, 5'd5, 32'hDEADBEEF, 1'b0};
      vecs[1] = '{1'b1, 5'd0, 32'h00001234, 1'b0, 1'b0, 5'd0, 32'h00000000, 1'b0};
      vecs[2] = '{1'b1, 5'd4, 32'h00000001, 1'b1, 1'b0, 5'd4, 32'h00000001, 1'b1};
      vecs[3] = '{1'b1, 5'd4, 32'h00000001, 1'b0, 1'b0, 5'd4, 32'h00000001, 1'b0};
      vecs[4] = '{1'b0, 5'd1, 32'h00000000, 1'b0, 1'b0, 5'd5, 32'hDEADBEEF, 1'b0};
      vecs[5] = '{1'b1, 5'd9, 32'h000000AA, 1'b0, 1'b1, 5'd9, 32'h000000AA, 1'b0};
      vecs[6] = '{1'b1, 5'd9, 32'h000000BB, 1'b0, 1'b0, 5'd9, 32'h000000BB, 1'b0};
      vecs[7] = '{1'b1, 5'd3, 32'h00000007, 1'b1, 1'b0, 5'd3, 32'h00000007, 1'b1};

      test_en = 1'b0; idle(); ra = '0; rb = '0; waddr = '0; wdata = '0;
      mreset();
      #1 rst_n = 1'b0;
      #1;
      chk("reset_busy0", 32'(busy0), 0);
      chk("reset_done0", 32'(done0), 0);
      chk("reset_busy1", 32'(busy1), 0);
      chk("reset_rdata0", rda0, 0);
      chk("reset_perr0", 32'(pea0), 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++) begin
         we = vecs[i].we; waddr = vecs[i].waddr; wdata = vecs[i].wdata;
         inj = vecs[i].inj; ckpt = vecs[i].ckpt; ra = vecs[i].ra; rb = 5'd0;
         cycle();
         chk($sformatf("vec%0d_rdata", i), rda0, vecs[i].exp_rd);
         chk($sformatf("vec%0d_perr", i), 32'(pea0), 32'(vecs[i].exp_perr));
      end
      idle();

      // Checkpoint was taken together with x9=0xAA.
      run_replay();
      rd_chk("rb1_x9", 5'd9, 32'hAA, 1'b0);
      rd_chk("rb1_x3", 5'd3, 32'h0, 1'b0);
      rd_chk("rb1_x5", 5'd5, 32'hDEADBEEF, 1'b0);
      rd_chk("rb1_x4", 5'd4, 32'h1, 1'b0);

      wr(5'd3, 32'h11, 1'b0);
      idle(); ckpt = 1'b1; cycle(); idle();
      wr(5'd3, 32'h22, 1'b0);
      wr(5'd7, 32'h33, 1'b0);
      rd_chk("pre_x7", 5'd7, 32'h33, 1'b0);
      run_replay();
      rd_chk("rb2_x3", 5'd3, 32'h11, 1'b0);
      rd_chk("rb2_x7", 5'd7, 32'h0, 1'b0);

      wr(5'd20, 32'h55, 1'b0);
      ra = 5'd20; cycle();
      chk("x20_d0", rda0, 32'h55);
      chk("x20_d1", rda1, 32'h0);

      // Abort a restore with reset 10 cycles in, while writes/checkpoints are being offered.
      idle(); replay = 1'b1; ra = 5'd5;
      cycle();
      replay = 1'b0; we = 1'b1; waddr = 5'd5; wdata = 32'h1; ckpt = 1'b1;
      for (int i = 0; i < 9; i++) cycle();
      idle();
      #2 rst_n = 1'b0;
      mreset();
      #1;
      chk("abort_busy0", 32'(busy0), 0);
      chk("abort_busy1", 32'(busy1), 0);
      chk("abort_done0", 32'(done0), 0);
      chk("abort_done1", 32'(done1), 0);
      chk("abort_rdata0", rda0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) cycle();
      rd_chk("post_rst_x5", 5'd5, 32'h0, 1'b0);
      rd_chk("post_rst_x9", 5'd9, 32'h0, 1'b0);

      for (int i = 0; i < 1500; i++) begin
         we     = 1'($urandom_range(0, 1));
         waddr  = 5'($urandom);
         wdata  = $urandom;
         inj    = ($urandom_range(0, 9) == 0);
         ckpt   = ($urandom_range(0, 19) == 0);
         replay = ($urandom_range(0, 49) == 0);
         ra     = 5'($urandom);
         rb     = 5'($urandom);
         cycle();
      end
      idle();

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
